// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 core control blocks: reset-sequence states,
// stack page and the fixed hardware vector addresses.
package cpu_pkg;

    typedef enum logic [2:0] {
        StHold,
        StDummy,
        StVecLo,
        StVecHi,
        StRun
    } rst_state_e;

    localparam logic [7:0]  STACK_PAGE = 8'h01;

    localparam logic [15:0] VEC_NMI    = 16'hFFFA;
    localparam logic [15:0] VEC_RESET  = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ    = 16'hFFFE;

endpackage

// File: rtl/mem_rd_port.sv
// Single-outstanding read port: owns the registered req/addr pair, holds them until
// acked, and forces one idle cycle between consecutive requests.
module mem_rd_port
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [15:0] rd_addr,
    output logic        rd_done,
    output logic [7:0]  rd_data,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q  <= 1'b0;
            addr_q <= 16'h0000;
        end else begin
            req_q  <= req_d;
            addr_q <= addr_d;
        end
    end

    // Ack takes priority, so the cycle after completion is always idle even if
    // the FSM still wants another read.
    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        if (req_q && mem_ack) begin
            req_d = 1'b0;
        end else if (!req_q && rd_req) begin
            req_d  = 1'b1;
            addr_d = rd_addr;
        end
    end

    assign rd_done  = req_q & mem_ack;
    assign rd_data  = mem_rdata;
    assign mem_req  = req_q;
    assign mem_addr = addr_q;

endmodule

// File: rtl/cpu_reset_seq.sv
// Reset-release sequencer: replays the 6502 reset micro-sequence (suppressed stack
// reads, vector fetch) and then hands PC, SP and I to the core.
module cpu_reset_seq
    import cpu_pkg::*;
#(
    parameter logic [15:0] VEC_ADDR = VEC_RESET,
    parameter logic [7:0]  SP_INIT  = 8'h00,
    parameter int unsigned N_DUMMY  = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] pc_out,
    output logic [7:0]  sp_out,
    output logic        i_flag,
    output logic        cpu_run,
    output logic        busy
);

    localparam logic [15:0] VecHiAddr = VEC_ADDR + 16'd1;
    localparam logic [2:0]  LastDummy = 3'(N_DUMMY - 1);
    localparam bit          SkipDummy = (N_DUMMY == 0);

    rst_state_e  state_q, state_d;
    logic [7:0]  sp_q, sp_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] pc_q, pc_d;
    logic        i_flag_q;

    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_done;
    logic [7:0]  rd_data;

    mem_rd_port u_rd_port (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_done   (rd_done),
        .rd_data   (rd_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StHold;
            sp_q     <= SP_INIT;
            cnt_q    <= 3'd0;
            lo_q     <= 8'h00;
            pc_q     <= 16'h0000;
            i_flag_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            pc_q     <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        pc_d    = pc_q;
        rd_req  = 1'b0;
        rd_addr = 16'h0000;
        case (state_q)
            StHold: begin
                state_d = SkipDummy ? StVecLo : StDummy;
            end
            StDummy: begin
                rd_req  = 1'b1;
                rd_addr = {STACK_PAGE, sp_q};
                if (rd_done) begin
                    sp_d  = sp_q - 8'd1;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == LastDummy) begin
                        state_d = StVecLo;
                    end
                end
            end
            StVecLo: begin
                rd_req  = 1'b1;
                rd_addr = VEC_ADDR;
                if (rd_done) begin
                    lo_d    = rd_data;
                    state_d = StVecHi;
                end
            end
            StVecHi: begin
                rd_req  = 1'b1;
                rd_addr = VecHiAddr;
                if (rd_done) begin
                    pc_d    = {rd_data, lo_q};
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StHold;
            end
        endcase
    end

    assign pc_out  = pc_q;
    assign sp_out  = sp_q;
    assign i_flag  = i_flag_q;
    assign cpu_run = (state_q == StRun);
    assign busy    = (state_q == StDummy) || (state_q == StVecLo) || (state_q == StVecHi);

endmodule

// File: tb/tb_cpu_reset_seq.sv
// Bench for cpu_reset_seq: four parameterisations share one memory responder with
// configurable wait states and spurious acks; results are compared against a model.
module tb_cpu_reset_seq;

    localparam int NI = 4;
    // Per-instance parameters, instance 0 in the lowest slice.
    localparam logic [NI*16-1:0] VA_P = {16'hFFFF, 16'hFFFC, 16'hFFFC, 16'hFFFC};
    localparam logic [NI*8-1:0]  SP_P = {8'h00, 8'h00, 8'h02, 8'h00};
    localparam logic [NI*4-1:0]  N_P  = {4'd3, 4'd0, 4'd3, 4'd3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst;
    logic [NI-1:0] ack_v = '0;
    logic [NI-1:0] req_v, run_v, busy_v, iflag_v;
    logic [7:0]    rdata = 8'h00;
    logic [15:0]   addr_v [NI];
    logic [15:0]   pc_v   [NI];
    logic [7:0]    sp_v   [NI];

    logic [7:0]    mem [65536];
    int            sel = 0;
    int            wait_n = 0;
    int            wcnt = 0;
    bit            spur = 1'b0;
    logic [15:0]   log_q [$];
    int            tests = 0;
    int            fails = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        cpu_reset_seq #(
            .VEC_ADDR (VA_P[g*16 +: 16]),
            .SP_INIT  (SP_P[g*8 +: 8]),
            .N_DUMMY  (N_P[g*4 +: 4])
        ) dut (
            .clk       (clk),
            .reset     (rst[g]),
            .mem_req   (req_v[g]),
            .mem_addr  (addr_v[g]),
            .mem_ack   (ack_v[g]),
            .mem_rdata (rdata),
            .pc_out    (pc_v[g]),
            .sp_out    (sp_v[g]),
            .i_flag    (iflag_v[g]),
            .cpu_run   (run_v[g]),
            .busy      (busy_v[g])
        );
    end

    // Memory responder for the selected instance; acks after wait_n idle cycles.
    always @(negedge clk) begin
        ack_v <= '0;
        if (req_v[sel]) begin
            if (wcnt == wait_n) begin
                ack_v[sel] <= 1'b1;
                rdata      <= mem[addr_v[sel]];
                log_q.push_back(addr_v[sel]);
                wcnt       <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
            if (spur) ack_v[sel] <= 1'($urandom);
        end
    end

    task automatic run_one(input int s, output int lat, output bit busy_ok, output bit to);
        log_q.delete();
        @(negedge clk);
        rst[s]  = 1'b0;
        lat     = 0;
        to      = 1'b1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (run_v[s]) begin
                lat = n - 1;
                to  = 1'b0;
                break;
            end
            if (!busy_v[s]) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            tests++;
            if ({req_v[g], addr_v[g], pc_v[g], sp_v[g], iflag_v[g], run_v[g], busy_v[g]} !==
                {1'b0, 16'h0000, 16'h0000, SP_P[g*8 +: 8], 1'b1, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset_state[%0d]: got req=%b addr=%h pc=%h sp=%h i=%b run=%b busy=%b, want sp=%h and others idle",
                         g, req_v[g], addr_v[g], pc_v[g], sp_v[g], iflag_v[g], run_v[g], busy_v[g],
                         SP_P[g*8 +: 8]);
            end
        end
    endtask

    // Full sequence on instance s with w wait states per read; checked against the model.
    task automatic test_seq(input string name, input int s, input int w, input bit sp_en);
        logic [15:0] va, exp_pc;
        logic [7:0]  spi, exp_sp;
        int          nd, exp_lat, lat, nlog, bad;
        bit          busy_ok, to;
        logic [15:0] exp_q [$];

        va  = VA_P[s*16 +: 16];
        spi = SP_P[s*8 +: 8];
        nd  = int'(N_P[s*4 +: 4]);
        exp_q.delete();
        for (int i = 0; i < nd; i++) exp_q.push_back({8'h01, 8'(spi - 8'(i))});
        exp_q.push_back(va);
        exp_q.push_back(16'(va + 16'd1));
        exp_pc  = {mem[16'(va + 16'd1)], mem[va]};
        exp_sp  = 8'(spi - 8'(nd));
        exp_lat = (nd + 2) * (2 + w);

        rst[s] = 1'b1;
        sel    = s;
        wait_n = w;
        spur   = sp_en;
        repeat (3) @(negedge clk);
        run_one(s, lat, busy_ok, to);

        tests++;
        if (to) begin
            fails++;
            $display("FAIL %s timeout: cpu_run never rose, want latency %0d", name, exp_lat);
        end
        tests++;
        if (lat !== exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        tests++;
        bad = (log_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            if (log_q[i] !== exp_q[i]) bad = 1;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s addresses: got %p want %p", name, log_q, exp_q);
        end
        tests++;
        if ({pc_v[s], sp_v[s], iflag_v[s]} !== {exp_pc, exp_sp, 1'b1}) begin
            fails++;
            $display("FAIL %s result: got pc=%h sp=%h i=%b want pc=%h sp=%h i=1",
                     name, pc_v[s], sp_v[s], iflag_v[s], exp_pc, exp_sp);
        end
        tests++;
        if (!busy_ok || busy_v[s] !== 1'b0 || req_v[s] !== 1'b0) begin
            fails++;
            $display("FAIL %s busy/req: got busy_during=%b busy=%b req=%b want 1 0 0",
                     name, busy_ok, busy_v[s], req_v[s]);
        end

        // Spurious acks while running must not disturb anything.
        nlog = log_q.size();
        spur = 1'b1;
        repeat (6) @(negedge clk);
        tests++;
        if (run_v[s] !== 1'b1 || req_v[s] !== 1'b0 || log_q.size() != nlog || pc_v[s] !== exp_pc) begin
            fails++;
            $display("FAIL %s run_hold: got run=%b req=%b reads=%0d pc=%h want run=1 req=0 reads=%0d pc=%h",
                     name, run_v[s], req_v[s], log_q.size(), pc_v[s], nlog, exp_pc);
        end
        spur   = 1'b0;
        rst[s] = 1'b1;
    endtask

    task automatic test_mid_reset();
        int          lat, n;
        bit          busy_ok, to, found;
        logic [15:0] exp_q [$];
        int          bad;

        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        rst[0] = 1'b1;
        sel    = 0;
        wait_n = 2;
        spur   = 1'b0;
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        found  = 1'b0;
        for (n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (req_v[0] && addr_v[0] == 16'hFFFD) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL mid_reset reach_vec_hi: got no FFFD request want one");
        end
        rst[0] = 1'b1;
        mem[16'hFFFD] = 8'h56;
        run_one(0, lat, busy_ok, to);

        exp_q = '{16'h0100, 16'h01FF, 16'h01FE, 16'hFFFC, 16'hFFFD};
        tests++;
        bad = (log_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            if (log_q[i] !== exp_q[i]) bad = 1;
        if (bad != 0 || to) begin
            fails++;
            $display("FAIL mid_reset addresses: got %p timeout=%b want %p", log_q, to, exp_q);
        end
        tests++;
        if (pc_v[0] !== 16'h5634 || sp_v[0] !== 8'hFD || lat != 20) begin
            fails++;
            $display("FAIL mid_reset result: got pc=%h sp=%h lat=%0d want pc=5634 sp=fd lat=20",
                     pc_v[0], sp_v[0], lat);
        end
        rst[0] = 1'b1;
    endtask

    task automatic test_random();
        int s, w;
        for (int k = 0; k < 8; k++) begin
            s = $urandom_range(0, NI - 1);
            w = $urandom_range(0, 3);
            mem[16'hFFFC] = 8'($urandom);
            mem[16'hFFFD] = 8'($urandom);
            mem[16'hFFFF] = 8'($urandom);
            mem[16'h0000] = 8'($urandom);
            test_seq($sformatf("random%0d", k), s, w, 1'($urandom));
        end
    endtask

    initial begin
        rst = '1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + 3);
        repeat (3) @(negedge clk);

        test_reset();
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        test_seq("default", 0, 0, 1'b0);
        test_seq("wait2", 0, 2, 1'b0);
        test_seq("sp_wrap", 1, 0, 1'b0);
        test_seq("ndummy0_spurious", 2, 0, 1'b1);
        mem[16'hFFFF] = 8'hCD;
        mem[16'h0000] = 8'hAB;
        test_seq("vec_wrap", 3, 1, 1'b0);
        test_mid_reset();
        test_random();
        test_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_reset_seq.md
# cpu_reset_seq

Reset-release sequencer for the 6502 core. It sits between `porf_gen` and the CPU datapath, and consumes the conditioned reset. After reset deasserts, it replays the 6502 reset micro-sequence: three suppressed stack reads with SP decrementing, then the vector fetch from `$FFFC`/`$FFFD`. It then presents the initial PC, SP and I flag to the core and releases it to run. It is the receiving end of the reset handshake that `porf_gen` drives.

## Interface
Parameters:
- `VEC_ADDR`, 16'hFFFC: address of vector low byte. The high byte is read from `VEC_ADDR+1`, with 16-bit wrap.
- `SP_INIT`, 8'h00: SP value loaded during reset.
- `N_DUMMY`, 3: number of suppressed stack reads, range 0–7.

Ports:
- `clk` input, 1: system clock. Single clock domain.
- `reset` input, 1: synchronous, active-high reset, driven by `porf_gen.reset_out`.
- `mem_req` output, 1: read request. Registered.
- `mem_addr` output, 16: read address. Registered; valid while `mem_req` is high.
- `mem_ack` input, 1: read completes on the cycle it is sampled high together with `mem_req`.
- `mem_rdata` input, 8: read data, sampled on the ack cycle.
- `pc_out` output, 16: fetched vector, `{hi,lo}`.
- `sp_out` output, 8: stack pointer after the dummy reads.
- `i_flag` output, 1: interrupt-disable flag for the core.
- `cpu_run` output, 1: core may begin instruction fetch.
- `busy` output, 1: sequence in progress.

## Operation
- States: `HOLD` → `DUMMY` → `VEC_LO` → `VEC_HI` → `RUN`.
- While `reset` is high, these values are forced every cycle:
  - state = `HOLD`, `mem_req`=0, `mem_addr`=0
  - `pc_out`=0, `sp_out`=`SP_INIT`, `i_flag`=1
  - `cpu_run`=0, `busy`=0, dummy count = 0
- `HOLD` → `DUMMY` on the first clock with `reset` low. If `N_DUMMY`=0, the target is `VEC_LO` instead. `busy` goes to 1 on entry.
- `DUMMY`:
  - Assert `mem_req` with `mem_addr` = `{8'h01, sp}`.
  - On ack: `sp` ← `sp`−1 (8-bit wrap, `00`→`FF`) and count++.
  - After the `N_DUMMY`-th ack, go to `VEC_LO`.
  - Read data is discarded. No writes are ever issued.
- `VEC_LO`: request `VEC_ADDR`. On ack, latch `lo` ← `mem_rdata` and go to `VEC_HI`.
- `VEC_HI`: request `VEC_ADDR+1`. On ack:
  - `pc_out` ← `{mem_rdata, lo}`
  - go to `RUN`
- `RUN`:
  - `mem_req`=0, `busy`=0, `cpu_run`=1
  - `i_flag` stays 1
  - outputs hold until the next reset
- Handshake rules:
  - `mem_req` and `mem_addr` stay stable until acked.
  - An ack while `mem_req`=0 is ignored.
  - After an ack, `mem_req` drops for exactly one cycle before the next request.
  - Wait states are unbounded.
- Reset mid-sequence, in any state: abort the next cycle and restart from `HOLD`. `sp` reloads `SP_INIT`; partial vector bytes are discarded.

## Timing
- Reset low sampled at edge E0:
  - E1: `mem_req` rises.
  - Zero wait states: each read costs 2 cycles (request cycle plus one idle cycle).
  - `cpu_run` rises 2·(`N_DUMMY`+2) cycles after E0; with the default `N_DUMMY`=3, that is 10 cycles.
- Each wait state adds exactly one cycle per read.
- `pc_out` and `sp_out` are registered. Both are valid in the same cycle `cpu_run` first reads 1.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum
  - `STACK_PAGE` = 8'h01
  - `VEC_RESET` = 16'hFFFC, `VEC_NMI` = 16'hFFFA, `VEC_IRQ` = 16'hFFFE, for later reuse by the interrupt sequencer
- One natural sub-module, `mem_rd_port`: owns the req/ack register pair and the one-cycle gap. It returns a `rd_done` strobe plus data to the FSM.

## Test plan
- Default parameters, memory FFFC=34, FFFD=12, zero wait:
  - reads at 0100, 01FF, 01FE, FFFC, FFFD
  - `pc_out`=1234, `sp_out`=FD, `i_flag`=1
  - `cpu_run` high 10 cycles after reset release
- Same, with 2 wait states on every read → identical addresses and results; `cpu_run` 20 cycles after release.
- `SP_INIT`=02, `N_DUMMY`=3 → dummy addresses 0102, 0101, 0100; `sp_out`=FF (wrap).
- `reset` reasserted for 1 cycle during `VEC_HI`, with FFFD changed to 56 before the restart:
  - sequence restarts at 0100
  - final `pc_out`=5634
  - no stale byte is kept
- Spurious `mem_ack` pulses during `HOLD` and `RUN`, and `N_DUMMY`=0:
  - the pulses are ignored
  - only FFFC and FFFD are read
  - `cpu_run` 4 cycles after release
- `VEC_ADDR`=FFFF → high byte read from 0000 (address wrap).
